// File: rtl/wdt_timer.sv
// Watchdog timer: counts ticks while enabled and holds timeout once the count reaches the limit.
// Optional tick prescaler is compiled in when WDT_PRESCALE_EN is defined.
module wdt_timer #(
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRED = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_WDEN   = 2'd0;
  localparam logic [1:0] ADDR_WDLIVE = 2'd1;
  localparam logic [1:0] ADDR_WTOCNT = 2'd2;
  localparam logic [1:0] ADDR_CNT    = 2'd3;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] wtocnt, wtocnt_nxt;
  logic             wden, wden_nxt;
  logic             tick;

  logic wr_wden, wr_lim, enable_evt, disable_evt, kick_evt, restart;

  assign wr_wden     = reg_wr && (reg_addr == ADDR_WDEN);
  assign wr_lim      = reg_wr && (reg_addr == ADDR_WTOCNT);
  assign disable_evt = wr_wden && !reg_wdata[0];
  assign enable_evt  = wr_wden && reg_wdata[0] && (state == IDLE);
  // A kick only counts once the watchdog is running or has fired.
  assign kick_evt    = reg_wr && (reg_addr == ADDR_WDLIVE) && reg_wdata[0]
                       && wden && (state != IDLE);
  assign restart     = enable_evt || kick_evt || disable_evt;

`ifdef WDT_PRESCALE_EN
  localparam int PS_W = $clog2(PRESCALE);

  logic [PS_W-1:0] pre;

  assign tick = (state == COUNT) && (pre == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else if (restart || (state != COUNT) || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PS_W'(1);
    end
  end
`else
  localparam int unused_prescale = PRESCALE;

  assign tick = 1'b1;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    wden_nxt   = wden;
    wtocnt_nxt = wtocnt;

    if (wr_lim)  wtocnt_nxt = reg_wdata[CNT_W-1:0];
    if (wr_wden) wden_nxt   = reg_wdata[0];

    // Priority: disable, then enable/kick, then the tick-driven count or fire.
    if (disable_evt) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (enable_evt || kick_evt) begin
      state_nxt = COUNT;
      cnt_nxt   = '0;
    end else if ((state == COUNT) && tick) begin
      if (cnt == wtocnt) state_nxt = FIRED;
      else               cnt_nxt   = cnt + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wtocnt  <= '0;
      wden    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wtocnt  <= wtocnt_nxt;
      wden    <= wden_nxt;
      timeout <= (state_nxt == FIRED);
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_WDEN:   reg_rdata = {31'd0, wden};
      ADDR_WDLIVE: reg_rdata = '0;
      ADDR_WTOCNT: reg_rdata = 32'(wtocnt);
      ADDR_CNT:    reg_rdata = 32'(cnt);
      default:     reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_wdt_timer.sv
// Self-checking bench for wdt_timer (default build, no prescaler) against a rule-level reference model.
module tb_wdt_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_wr = 1'b0;
  logic [1:0]  reg_addr = 2'd0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        timeout;

  int compares = 0;
  int errors   = 0;

  // Reference model: enable flag, running/fired flags, live count and limit.
  bit          m_en, m_run, m_fired;
  logic [31:0] m_cnt, m_lim;

  wdt_timer #(.CNT_W(32), .PRESCALE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_en = 0; m_run = 0; m_fired = 0; m_cnt = '0; m_lim = '0;
  endtask

  task automatic model_edge(input bit wr, input logic [1:0] a, input logic [31:0] d);
    if (wr && a == 2'd0 && !d[0]) begin
      m_en = 0; m_run = 0; m_fired = 0; m_cnt = '0;
    end else if (wr && a == 2'd0 && d[0] && !m_run && !m_fired) begin
      m_en = 1; m_run = 1; m_cnt = '0;
    end else if (wr && a == 2'd1 && d[0] && m_en && (m_run || m_fired)) begin
      m_run = 1; m_fired = 0; m_cnt = '0;
    end else if (m_run) begin
      if (m_cnt == m_lim) begin m_run = 0; m_fired = 1; end
      else m_cnt = m_cnt + 1;
    end
    if (wr && a == 2'd0) m_en = d[0];
    if (wr && a == 2'd2) m_lim = d;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {31'd0, m_en};
      2'd2:    return m_lim;
      2'd3:    return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: drive at negedge, update model at posedge, then leave CNT selected for reading.
  task automatic step(input bit wr, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_wr = wr; reg_addr = a; reg_wdata = d;
    @(posedge clk);
    model_edge(wr, a, d);
    #1;
    reg_wr = 1'b0; reg_addr = 2'd3;
    #1;
  endtask

  task automatic idle(); step(1'b0, 2'd0, 32'd0); endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #3;
    for (int a = 0; a < 4; a++) begin
      reg_addr = 2'(a);
      #1;
      if (reg_rdata !== 32'd0) begin
        $display("FAIL reset_rdata addr=%0d got=%h want=0", a, reg_rdata); errors++;
      end
      compares++;
    end
    if (timeout !== 1'b0) begin
      $display("FAIL reset_timeout got=%b want=0", timeout); errors++;
    end
    compares++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fire();
    int first = 0;
    step(1'b1, 2'd2, 32'd5);
    step(1'b1, 2'd0, 32'd1);              // edge E0
    for (int k = 1; k <= 9; k++) begin
      idle();
      if (timeout && first == 0) first = k;
      if (timeout !== m_fired || reg_rdata !== m_cnt) begin
        $display("FAIL fire_cycle k=%0d got to=%b cnt=%0d want to=%b cnt=%0d",
                 k, timeout, reg_rdata, m_fired, m_cnt); errors++;
      end
      compares++;
    end
    if (first !== 6) begin
      $display("FAIL fire_latency got=E0+%0d want=E0+6", first); errors++;
    end
    compares++;
    if (reg_rdata !== 32'd5 || timeout !== 1'b1) begin
      $display("FAIL fire_frozen got cnt=%0d to=%b want cnt=5 to=1", reg_rdata, timeout); errors++;
    end
    compares++;
  endtask

  task automatic test_kick();
    int first = 0;
    step(1'b1, 2'd1, 32'd1);
    if (timeout !== 1'b0 || reg_rdata !== 32'd0) begin
      $display("FAIL kick_clear got to=%b cnt=%0d want to=0 cnt=0", timeout, reg_rdata); errors++;
    end
    compares++;
    for (int k = 1; k <= 8; k++) begin
      idle();
      if (timeout && first == 0) first = k;
    end
    if (first !== 6) begin
      $display("FAIL kick_refire got=Ek+%0d want=Ek+6", first); errors++;
    end
    compares++;
  endtask

  task automatic test_kick_at_fire();
    bit seen = 0;
    step(1'b1, 2'd0, 32'd0);
    step(1'b1, 2'd2, 32'd3);
    step(1'b1, 2'd0, 32'd1);              // E0: cnt=0
    for (int k = 0; k < 3; k++) idle();   // E1..E3: cnt reaches 3
    if (reg_rdata !== 32'd3) begin
      $display("FAIL kick_fire_pre got cnt=%0d want 3", reg_rdata); errors++;
    end
    compares++;
    step(1'b1, 2'd1, 32'd1);              // kick on the would-be fire edge
    if (timeout) seen = 1;
    idle();
    if (timeout) seen = 1;
    if (seen !== 1'b0 || reg_rdata !== 32'd1) begin
      $display("FAIL kick_beats_fire got pulse=%b cnt=%0d want pulse=0 cnt=1", seen, reg_rdata); errors++;
    end
    compares++;
  endtask

  task automatic test_limit_zero();
    step(1'b1, 2'd0, 32'd0);
    step(1'b1, 2'd2, 32'd0);
    step(1'b1, 2'd0, 32'd1);
    if (timeout !== 1'b0) begin
      $display("FAIL lim0_e0 got to=%b want 0", timeout); errors++;
    end
    compares++;
    idle();
    if (timeout !== 1'b1 || reg_rdata !== 32'd0) begin
      $display("FAIL lim0_fire got to=%b cnt=%0d want to=1 cnt=0", timeout, reg_rdata); errors++;
    end
    compares++;
    step(1'b1, 2'd0, 32'd0);              // disable beats the held fire
    if (timeout !== 1'b0) begin
      $display("FAIL disable_fired got to=%b want 0", timeout); errors++;
    end
    compares++;
  endtask

  task automatic test_async_reset();
    step(1'b1, 2'd2, 32'd9);
    step(1'b1, 2'd0, 32'd1);
    idle(); idle();                       // cnt = 2
    if (reg_rdata !== 32'd2) begin
      $display("FAIL areset_pre got cnt=%0d want 2", reg_rdata); errors++;
    end
    compares++;
    #1 rst = 1'b0;
    model_reset();
    #1;
    if (reg_rdata !== 32'd0 || timeout !== 1'b0) begin
      $display("FAIL areset_cnt got cnt=%0d to=%b want 0/0", reg_rdata, timeout); errors++;
    end
    compares++;
    reg_addr = 2'd0;
    #1;
    if (reg_rdata !== 32'd0) begin
      $display("FAIL areset_wden got=%0d want 0", reg_rdata); errors++;
    end
    compares++;
    @(negedge clk) rst = 1'b1;
    step(1'b1, 2'd1, 32'd1);
    idle();
    if (reg_rdata !== 32'd0 || timeout !== 1'b0) begin
      $display("FAIL kick_disabled got cnt=%0d to=%b want 0/0", reg_rdata, timeout); errors++;
    end
    compares++;
    // A held timeout must also drop without a clock edge.
    step(1'b1, 2'd0, 32'd1);
    idle();
    #1 rst = 1'b0;
    model_reset();
    #1;
    if (timeout !== 1'b0) begin
      $display("FAIL areset_timeout got=%b want 0", timeout); errors++;
    end
    compares++;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_random();
    int op;
    logic [1:0]  a;
    logic [31:0] d;
    bit          wr;
    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 11);
      wr = 1; d = $urandom;
      case (op)
        0:       begin a = 2'd0; d[0] = 1'b0; end
        1, 2:    begin a = 2'd0; d[0] = 1'b1; end
        3, 4:    begin a = 2'd1; d[0] = 1'b1; end
        5:       begin a = 2'd1; d[0] = 1'b0; end
        6:       begin a = 2'd2; d = $urandom_range(0, 12); end
        7:       begin a = 2'd3; end
        default: begin wr = 0; a = 2'd0; end
      endcase
      step(wr, a, d);
      if (timeout !== m_fired || reg_rdata !== m_cnt) begin
        $display("FAIL random i=%0d got to=%b cnt=%0d want to=%b cnt=%0d",
                 i, timeout, reg_rdata, m_fired, m_cnt); errors++;
      end
      compares++;
      reg_addr = 2'($urandom_range(0, 2));
      #1;
      if (reg_rdata !== model_read(reg_addr)) begin
        $display("FAIL random_read i=%0d addr=%0d got=%h want=%h",
                 i, reg_addr, reg_rdata, model_read(reg_addr)); errors++;
      end
      compares++;
    end
  endtask

  initial begin
    test_reset();
    test_fire();
    test_kick();
    test_kick_at_fire();
    test_limit_zero();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
